// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver.
//   The serial input is synchronised, then each bit is sampled three times around its centre and
//   the majority value is kept. Frames carry a start bit, DATA_BITS data bits (LSB first), an
//   optional parity bit and STOP_BITS stop bits. A completed word is presented on data with a
//   valid/ready handshake, and error conditions are reported as one-cycle pulses.
// Ports:
//   clk        oversample clock (OVERSAMPLE x baud)
//   rst_n      asynchronous active-low reset
//   en         receiver enable; low aborts any frame and clears valid/flags
//   rx         asynchronous serial line, idle high
//   data       received word, held stable while valid is high
//   valid      word available
//   ready      consumer accepts the word when valid && ready
//   busy       frame in progress
//   frame_err  pulse: a stop bit was sampled low (frame dropped)
//   parity_err pulse: parity mismatch (frame dropped)
//   overrun    pulse: good frame completed while the previous word was still unaccepted
module uart_rx_ovs #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam int unsigned IdxW = $clog2(DATA_BITS);
   localparam int unsigned Mid  = OVERSAMPLE / 2;

   localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
   localparam logic [CntW-1:0] SmpA    = CntW'(Mid - 1);
   localparam logic [CntW-1:0] SmpB    = CntW'(Mid);
   localparam logic [CntW-1:0] SmpC    = CntW'(Mid + 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                 state_q;
   logic                   meta_q, rs_q;
   logic [CntW-1:0]        cnt_q;
   logic [IdxW-1:0]        idx_q;
   logic                   stop_idx_q;
   logic [1:0]             smp_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_q;
   logic                   stop_ok_q;
   logic                   done_q;
   logic                   armed_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q, ferr_q, perr_q, ovr_q;

   logic vote, at_vote, at_wrap, stop_last, par_ok;

   // Third sample is the live synchroniser output, taken at cnt = MID+1.
   assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rs_q) | (smp_q[1] & rs_q);
   assign at_vote   = (cnt_q == SmpC);
   assign at_wrap   = (cnt_q == CntLast);
   assign stop_last = (stop_idx_q == 1'(STOP_BITS - 1));
   // Even: parity bit equals XOR of data; odd: its complement.
   assign par_ok    = (PARITY == 0) || (par_q == ((^shift_q) ^ 1'(PARITY == 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         meta_q     <= 1'b1;
         rs_q       <= 1'b1;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_idx_q <= 1'b0;
         smp_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         stop_ok_q  <= 1'b0;
         done_q     <= 1'b0;
         armed_q    <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         meta_q <= rx;
         rs_q   <= meta_q;
         ferr_q <= 1'b0;
         perr_q <= 1'b0;
         ovr_q  <= 1'b0;
         done_q <= 1'b0;
         if (!en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
         end else begin
            if (valid_q && ready) valid_q <= 1'b0;
            // Completion of the frame whose last stop vote was taken last cycle.
            if (done_q) begin
               if (!stop_ok_q) begin
                  ferr_q <= 1'b1;
               end else if (!par_ok) begin
                  perr_q <= 1'b1;
               end else if (valid_q && !ready) begin
                  ovr_q <= 1'b1;
               end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
               end
            end
            if (state_q != StIdle) begin
               cnt_q <= at_wrap ? '0 : cnt_q + CntW'(1);
               if (cnt_q == SmpA) smp_q[0] <= rs_q;
               if (cnt_q == SmpB) smp_q[1] <= rs_q;
            end
            case (state_q)
               StIdle: begin
                  cnt_q <= '0;
                  if (rs_q) begin
                     armed_q <= 1'b1;
                  end else if (armed_q) begin
                     // The detecting cycle counts as cnt = 0 of the start bit.
                     armed_q <= 1'b0;
                     state_q <= StStart;
                     cnt_q   <= CntW'(1);
                  end
               end
               StStart: begin
                  if (at_vote && vote) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                  end else if (at_wrap) begin
                     state_q <= StData;
                     idx_q   <= '0;
                  end
               end
               StData: begin
                  if (at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                  if (at_wrap) begin
                     if (idx_q == IdxLast) begin
                        state_q    <= (PARITY != 0) ? StParity : StStop;
                        stop_idx_q <= 1'b0;
                        stop_ok_q  <= 1'b1;
                     end else begin
                        idx_q <= idx_q + IdxW'(1);
                     end
                  end
               end
               StParity: begin
                  if (at_vote) par_q <= vote;
                  if (at_wrap) state_q <= StStop;
               end
               StStop: begin
                  if (at_vote) begin
                     stop_ok_q <= stop_ok_q & vote;
                     // Leave mid-bit so a slightly fast transmitter is not missed.
                     if (stop_last) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                     end
                  end else if (at_wrap) begin
                     stop_idx_q <= stop_idx_q + 1'b1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign busy       = (state_q != StIdle);
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs (8 data bits, x16, even parity, 2 stop bits). Frames are driven
// bit-by-bit; each frame's outcome and its completion cycle are predicted from the line timing
// and fed to an output model that is compared against the DUT on every cycle.
module tb_uart_rx_ovs;

   localparam int OS    = 16;
   localparam int MID   = OS / 2;
   localparam int DB    = 8;
   localparam int NSTOP = 2;
   localparam int NB    = 1 + DB + 1 + NSTOP;
   localparam int KOk   = 0;
   localparam int KFe   = 1;
   localparam int KPe   = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b1;
   logic          rx    = 1'b1;
   logic          ready = 1'b1;
   logic [DB-1:0] data;
   logic          valid, busy, frame_err, parity_err, overrun;

   uart_rx_ovs #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .PARITY    (2),
      .STOP_BITS (NSTOP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .busy      (busy),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            at;
      int            kind;
      logic [DB-1:0] w;
   } ev_t;

   typedef struct packed {
      logic [DB-1:0] d;
      logic          v, fe, pe, ov;
   } mst_t;

   int   n_cmp = 0, n_bad = 0, cyc = 0;
   int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, v_cnt = 0;
   bit   checking = 1'b0, rr_en = 1'b0;
   ev_t  evq[$];
   int   blo[$], bhi[$];
   mst_t m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Output model: expected state after clock edge number e.
   function automatic mst_t model_next(input mst_t s, input int e);
      mst_t n = s;
      n.fe = 1'b0;
      n.pe = 1'b0;
      n.ov = 1'b0;
      if (!en) begin
         evq.delete();
         n.v = 1'b0;
         return n;
      end
      if (s.v && ready) n.v = 1'b0;
      if (evq.size() > 0 && evq[0].at == e) begin
         case (evq[0].kind)
            KFe:     n.fe = 1'b1;
            KPe:     n.pe = 1'b1;
            default: begin
               if (n.v) n.ov = 1'b1;
               else begin
                  n.d = evq[0].w;
                  n.v = 1'b1;
               end
            end
         endcase
         void'(evq.pop_front());
      end
      return n;
   endfunction

   function automatic bit exp_busy();
      for (int i = 0; i < blo.size(); i++)
         if (cyc >= blo[i] && cyc < bhi[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evq.delete();
         m <= '0;
      end else begin
         m <= model_next(m, cyc + 1);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("valid", valid, m.v);
         chk("data", data, m.d);
         chk("busy", busy, exp_busy());
         chk("frame_err", frame_err, m.fe);
         chk("parity_err", parity_err, m.pe);
         chk("overrun", overrun, m.ov);
         fe_cnt <= fe_cnt + int'(frame_err);
         pe_cnt <= pe_cnt + int'(parity_err);
         ov_cnt <= ov_cnt + int'(overrun);
         v_cnt  <= v_cnt + int'(valid);
      end
   end

   task automatic tick(input logic v);
      @(posedge clk);
      #1;
      rx = v;
      if (rr_en) ready = 1'($urandom_range(1, 0));
   endtask

   task automatic wait_n(input int n);
      repeat (n) tick(rx);
   endtask

   // Drives one frame; predicts its busy window and completion cycle from the start-bit cycle.
   task automatic send_frame(input logic [DB-1:0] w, input bit bad_par, input int bad_stop,
                             input bit spike, input int brk, input int gap);
      logic [NB-1:0] bits;
      int ps, sp, kind;
      bits[0]      = 1'b0;
      bits[DB:1]   = w;
      bits[DB+1]   = (^w) ^ bad_par;
      for (int s = 0; s < NSTOP; s++) bits[DB+2+s] = (s == bad_stop) ? 1'b0 : 1'b1;
      kind = (bad_stop >= 0) ? KFe : (bad_par ? KPe : KOk);
      for (int b = 0; b < NB; b++) begin
         sp = (spike && b >= 1 && b <= DB) ? $urandom_range(OS - 1, 1) : 0;
         for (int i = 0; i < OS; i++) begin
            tick((sp != 0 && i == sp) ? ~bits[b] : bits[b]);
            if (b == 0 && i == 0) begin
               ps = cyc;
               blo.push_back(ps + 3);
               bhi.push_back(ps + (NB - 1) * OS + MID + 4);
               evq.push_back('{at: ps + (NB - 1) * OS + MID + 5, kind: kind, w: w});
            end
         end
      end
      repeat (brk) tick(1'b0);
      repeat (gap) tick(1'b1);
   endtask

   // Start bit plus nb-1 data bits, to be aborted by the caller.
   task automatic send_partial(input logic [DB-1:0] w, input int nb);
      logic [DB:0] bits;
      bits = {w, 1'b0};
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < OS; i++) begin
            tick(bits[b]);
            if (b == 0 && i == 0) begin
               blo.push_back(cyc + 3);
               bhi.push_back(32'h3fff_ffff);
            end
         end
      end
   endtask

   task automatic glitch(input int n);
      tick(1'b0);
      blo.push_back(cyc + 3);
      bhi.push_back(cyc + MID + 4);
      repeat (n - 1) tick(1'b0);
      tick(1'b1);
   endtask

   initial begin
      int r, bs;
      repeat (2) @(posedge clk);
      #1;
      checking = 1'b1;
      wait_n(2);
      chk("reset_valid", valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_data", data, 0);
      chk("reset_flags", {frame_err, parity_err, overrun}, 0);
      rst_n = 1'b1;
      wait_n(5);

      // Plain frame, consumer ready.
      send_frame(8'hA5, 1'b0, -1, 1'b0, 0, 30);
      chk("t1_data", data, 8'hA5);
      chk("t1_model_data", m.d, 8'hA5);
      chk("t1_valid_cycles", v_cnt, 1);
      chk("t1_flags", fe_cnt + pe_cnt + ov_cnt, 0);

      // Wrong parity bit, then correct one.
      send_frame(8'h3C, 1'b1, -1, 1'b0, 0, 30);
      chk("t2_perr", pe_cnt, 1);
      chk("t2_data_kept", data, 8'hA5);
      send_frame(8'h3C, 1'b0, -1, 1'b0, 0, 30);
      chk("t2_data", data, 8'h3C);
      chk("t2_valid_cycles", v_cnt, 2);

      // Low stop bit followed by a break: one frame error, no re-trigger.
      send_frame(8'h77, 1'b0, NSTOP - 1, 1'b0, 3 * OS, 30);
      chk("t3_ferr", fe_cnt, 1);
      chk("t3_perr", pe_cnt, 1);
      chk("t3_data_kept", data, 8'h3C);

      // Short start glitch, then a frame with single-cycle spikes in every data bit.
      glitch(3);
      wait_n(2 * OS);
      chk("t5_no_busy", busy, 0);
      chk("t5_no_flags", fe_cnt + pe_cnt + ov_cnt, 2);
      send_frame(8'hC3, 1'b0, -1, 1'b1, 0, 30);
      chk("t5_data", data, 8'hC3);

      // Overrun while the consumer stalls.
      ready = 1'b0;
      send_frame(8'h11, 1'b0, -1, 1'b0, 0, 5);
      send_frame(8'h22, 1'b0, -1, 1'b0, 0, 30);
      chk("t4_data", data, 8'h11);
      chk("t4_valid", valid, 1);
      chk("t4_overrun", ov_cnt, 1);
      ready = 1'b1;
      wait_n(2);
      chk("t4_valid_fell", valid, 0);
      chk("t4_data_held", data, 8'h11);

      // Reset mid-frame.
      send_partial(8'h99, 5);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      rx    = 1'b1;
      bhi[bhi.size() - 1] = cyc;
      wait_n(3);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_data", data, 0);
      rst_n = 1'b1;
      wait_n(10);
      send_frame(8'h5A, 1'b0, -1, 1'b0, 0, 30);
      chk("t6_data_after_rst", data, 8'h5A);

      // Disable mid-frame.
      send_partial(8'h99, 4);
      @(posedge clk);
      #1;
      en = 1'b0;
      rx = 1'b1;
      bhi[bhi.size() - 1] = cyc + 1;
      wait_n(4);
      chk("t6_en_busy", busy, 0);
      chk("t6_en_valid", valid, 0);
      chk("t6_en_data_kept", data, 8'h5A);
      en = 1'b1;
      wait_n(10);
      send_frame(8'h5A, 1'b0, -1, 1'b0, 0, 30);
      chk("t6_data_after_en", data, 8'h5A);
      chk("t6_valid_seen", valid, 0);

      // Random traffic with a randomly stalling consumer.
      rr_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         r  = $urandom_range(9, 0);
         bs = (r == 1) ? $urandom_range(NSTOP - 1, 0) : -1;
         send_frame(8'($urandom), r == 0, bs, $urandom_range(2, 0) == 0, 0,
                    (bs >= 0) ? $urandom_range(8, 2) : $urandom_range(8, 0));
      end
      rr_en = 1'b0;
      ready = 1'b1;
      wait_n(40);
      chk("end_valid", valid, 0);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
